// File: rtl/token_encoder_pkg.sv
// Shared types and helpers for the streaming word tokenizer.
package token_encoder_pkg;

  // Controller states: collect a word, then alternate fetch/compare over the vocab.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FETCH,
    ST_CMP,
    ST_EMIT,
    ST_DONE
  } enc_state_t;

  // Token ID reserved for words that do not match any vocab entry (all ones).
  function automatic int unsigned unkId(input int unsigned tokenWidth);
    return (32'd1 << tokenWidth) - 32'd1;
  endfunction

  // Index width that never collapses to zero bits for single-entry arrays.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/token_encoder_if.sv
// Character stream in, vocab read port, token stream out.
// slave is the encoder side; master is the source / memory / sink side.
interface token_encoder_if #(
  parameter int CHAR_WIDTH  = 8,
  parameter int TOKEN_WIDTH = 8,
  parameter int VADDR_W     = 7
);

  logic                   char_valid;
  logic                   char_ready;
  logic [CHAR_WIDTH-1:0]  char_data;
  logic                   char_last;

  logic                   vocab_rd_en;
  logic [VADDR_W-1:0]     vocab_addr;
  logic [CHAR_WIDTH-1:0]  vocab_rd_data;

  logic                   tok_valid;
  logic                   tok_ready;
  logic [TOKEN_WIDTH-1:0] tok_data;
  logic                   tok_unk;
  logic                   tok_last;

  modport slave (
    input  char_valid, char_data, char_last, vocab_rd_data, tok_ready,
    output char_ready, vocab_addr, vocab_rd_en, tok_valid, tok_data, tok_unk, tok_last
  );

  modport master (
    output char_valid, char_data, char_last, vocab_rd_data, tok_ready,
    input  char_ready, vocab_addr, vocab_rd_en, tok_valid, tok_data, tok_unk, tok_last
  );

endinterface

// File: rtl/token_encoder_word_buf.sv
// Word buffer: stores the characters of the current word, tracks its length,
// flags overflow (truncation), zero-pads the tail and supports indexed reads.
module tok_word_buf
  import token_encoder_pkg::*;
#(
  parameter  int CHAR_WIDTH   = 8,
  parameter  int MAX_WORD_LEN = 8,
  localparam int KW           = idxWidth(MAX_WORD_LEN),
  localparam int LW           = $clog2(MAX_WORD_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr,
  input  logic [CHAR_WIDTH-1:0] i_wrData,
  input  logic                  i_pad,
  input  logic                  i_clr,
  input  logic [KW-1:0]         i_rdIdx,
  output logic [CHAR_WIDTH-1:0] o_rdData,
  output logic [LW-1:0]         o_lenNext,
  output logic                  o_truncNext
);

  logic [CHAR_WIDTH-1:0] r_buf [MAX_WORD_LEN];
  logic [LW-1:0]         r_len;
  logic                  r_trunc;
  logic                  w_room;
  logic [LW-1:0]         w_lenNext;

  assign w_room      = (r_len < LW'(MAX_WORD_LEN));
  assign w_lenNext   = (i_wr && w_room) ? (r_len + LW'(1)) : r_len;
  assign o_lenNext   = w_lenNext;
  assign o_truncNext = r_trunc | (i_wr & ~w_room);
  assign o_rdData    = r_buf[i_rdIdx];

  // Store / overflow / pad / clear; padding covers every slot past the (new) length.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      for (int i = 0; i < MAX_WORD_LEN; i++) begin
        r_buf[i] <= '0;
      end
      r_len   <= '0;
      r_trunc <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_WORD_LEN; i++) begin
        if (i_pad && (LW'(i) >= w_lenNext)) begin
          r_buf[i] <= '0;
        end
      end
      if (i_wr) begin
        if (w_room) begin
          r_buf[r_len[KW-1:0]] <= i_wrData;
          r_len                <= w_lenNext;
        end else begin
          r_trunc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/token_encoder.sv
// Streaming word tokenizer: splits characters into words on SEP_CHAR, searches
// each word linearly through an external vocab memory and emits one token per word.
module token_encoder
  import token_encoder_pkg::*;
#(
  parameter int                    CHAR_WIDTH   = 8,
  parameter int                    MAX_WORD_LEN = 8,
  parameter int                    VOCAB_DEPTH  = 16,
  parameter int                    TOKEN_WIDTH  = 8,
  parameter logic [CHAR_WIDTH-1:0] SEP_CHAR     = 8'h20,
  parameter int                    VADDR_W      = $clog2(VOCAB_DEPTH * MAX_WORD_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             drop_unk,
  output logic             busy,
  output logic             done,
  token_encoder_if.slave   bus
);

  localparam int KW = idxWidth(MAX_WORD_LEN);
  localparam int EW = idxWidth(VOCAB_DEPTH);
  localparam int LW = $clog2(MAX_WORD_LEN + 1);
  localparam logic [TOKEN_WIDTH-1:0] UNK_ID = TOKEN_WIDTH'(unkId(TOKEN_WIDTH));

  enc_state_t             r_state;
  logic                   r_drop;
  logic                   r_lastFlag;
  logic [EW-1:0]          r_entry;
  logic [KW-1:0]          r_charIdx;
  logic                   r_charReady;
  logic                   r_vocabRdEn;
  logic [VADDR_W-1:0]     r_vocabAddr;
  logic                   r_tokValid;
  logic [TOKEN_WIDTH-1:0] r_tokData;
  logic                   r_tokUnk;
  logic                   r_tokLast;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_isSep;
  logic                   w_accept;
  logic                   w_store;
  logic                   w_wordEnd;
  logic [LW-1:0]          w_lenAfter;
  logic                   w_truncAfter;
  logic [CHAR_WIDTH-1:0]  w_bufRd;
  logic                   w_bufClr;
  logic                   w_charMatch;
  logic                   w_lastEntry;
  logic                   w_lastChar;
  logic                   w_lastSel;
  logic                   w_unmatched;
  logic                   w_tokHs;
  logic [VADDR_W-1:0]     w_addrNextEntry;
  logic [VADDR_W-1:0]     w_addrNextChar;

  assign w_isSep      = (bus.char_data == SEP_CHAR);
  assign w_accept     = (r_state == ST_COLLECT) && bus.char_valid;
  assign w_store      = w_accept && !w_isSep;
  assign w_wordEnd    = w_accept && (w_isSep || bus.char_last);
  assign w_charMatch  = (bus.vocab_rd_data == w_bufRd);
  assign w_lastEntry  = (r_entry == EW'(VOCAB_DEPTH - 1));
  assign w_lastChar   = (r_charIdx == KW'(MAX_WORD_LEN - 1));
  assign w_tokHs      = (r_state == ST_EMIT) && bus.tok_ready;

  // While collecting, the word's end-of-stream status comes straight from char_last.
  assign w_lastSel    = (r_state == ST_COLLECT) ? bus.char_last : r_lastFlag;
  assign w_unmatched  = (w_wordEnd && (w_lenAfter != '0) && w_truncAfter) ||
                        ((r_state == ST_CMP) && !w_charMatch && w_lastEntry);

  // The buffer is emptied when a stream starts and whenever we return to collecting.
  assign w_bufClr     = ((r_state == ST_IDLE) && start) ||
                        (w_tokHs && !r_lastFlag) ||
                        (w_unmatched && r_drop && !w_lastSel);

  assign w_addrNextEntry = VADDR_W'((int'(r_entry) + 1) * MAX_WORD_LEN);
  assign w_addrNextChar  = VADDR_W'(int'(r_entry) * MAX_WORD_LEN + int'(r_charIdx) + 1);

  tok_word_buf #(
    .CHAR_WIDTH   (CHAR_WIDTH),
    .MAX_WORD_LEN (MAX_WORD_LEN)
  ) u_wordBuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr        (w_store),
    .i_wrData    (bus.char_data),
    .i_pad       (w_wordEnd),
    .i_clr       (w_bufClr),
    .i_rdIdx     (r_charIdx),
    .o_rdData    (w_bufRd),
    .o_lenNext   (w_lenAfter),
    .o_truncNext (w_truncAfter)
  );

  // Outputs are forced low while reset is held so nothing leaks out mid-abort.
  assign bus.char_ready  = r_charReady & rst_n;
  assign bus.vocab_rd_en = r_vocabRdEn & rst_n;
  assign bus.vocab_addr  = rst_n ? r_vocabAddr : '0;
  assign bus.tok_valid   = r_tokValid & rst_n;
  assign bus.tok_data    = rst_n ? r_tokData : '0;
  assign bus.tok_unk     = r_tokUnk & rst_n;
  assign bus.tok_last    = r_tokLast & rst_n;
  assign busy            = r_busy & rst_n;
  assign done            = r_done & rst_n;

  // Controller: state, search counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_drop      <= 1'b0;
      r_lastFlag  <= 1'b0;
      r_entry     <= '0;
      r_charIdx   <= '0;
      r_charReady <= 1'b0;
      r_vocabRdEn <= 1'b0;
      r_vocabAddr <= '0;
      r_tokValid  <= 1'b0;
      r_tokData   <= '0;
      r_tokUnk    <= 1'b0;
      r_tokLast   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_vocabRdEn <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_drop      <= drop_unk;
            r_charReady <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (w_wordEnd && (w_lenAfter == '0)) begin
            if (bus.char_last) begin
              r_charReady <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
            end
          end else if (w_wordEnd) begin
            r_lastFlag <= bus.char_last;
            if (!w_truncAfter) begin
              r_charReady <= 1'b0;
              r_entry     <= '0;
              r_charIdx   <= '0;
              r_vocabRdEn <= 1'b1;
              r_vocabAddr <= '0;
              r_state     <= ST_FETCH;
            end else if (!r_drop) begin
              r_charReady <= 1'b0;
              r_tokValid  <= 1'b1;
              r_tokData   <= UNK_ID;
              r_tokUnk    <= 1'b1;
              r_tokLast   <= bus.char_last;
              r_state     <= ST_EMIT;
            end else if (bus.char_last) begin
              r_charReady <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end

        ST_FETCH: begin
          r_state <= ST_CMP;
        end

        ST_CMP: begin
          if (!w_charMatch) begin
            if (!w_lastEntry) begin
              r_entry     <= r_entry + EW'(1);
              r_charIdx   <= '0;
              r_vocabRdEn <= 1'b1;
              r_vocabAddr <= w_addrNextEntry;
              r_state     <= ST_FETCH;
            end else if (!r_drop) begin
              r_tokValid <= 1'b1;
              r_tokData  <= UNK_ID;
              r_tokUnk   <= 1'b1;
              r_tokLast  <= r_lastFlag;
              r_state    <= ST_EMIT;
            end else if (r_lastFlag) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_charReady <= 1'b1;
              r_state     <= ST_COLLECT;
            end
          end else if ((bus.vocab_rd_data == '0) || w_lastChar) begin
            r_tokValid <= 1'b1;
            r_tokData  <= TOKEN_WIDTH'(r_entry);
            r_tokUnk   <= 1'b0;
            r_tokLast  <= r_lastFlag;
            r_state    <= ST_EMIT;
          end else begin
            r_charIdx   <= r_charIdx + KW'(1);
            r_vocabRdEn <= 1'b1;
            r_vocabAddr <= w_addrNextChar;
            r_state     <= ST_FETCH;
          end
        end

        ST_EMIT: begin
          if (bus.tok_ready) begin
            r_tokValid <= 1'b0;
            r_tokData  <= '0;
            r_tokUnk   <= 1'b0;
            r_tokLast  <= 1'b0;
            if (r_lastFlag) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_charReady <= 1'b1;
              r_state     <= ST_COLLECT;
            end
          end
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_token_encoder.sv
// Directed testbench for token_encoder with a behavioural vocab memory.
module tb_token_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic drop_unk;
  logic busy;
  logic done;

  logic [7:0] vocab [0:127];
  logic [9:0] tokQ [$];
  logic [6:0] addrQ [$];
  int doneCount = 0;
  int nCompared = 0;
  int nMismatched = 0;

  token_encoder_if #(.CHAR_WIDTH(8), .TOKEN_WIDTH(8), .VADDR_W(7)) bus();

  token_encoder #(
    .CHAR_WIDTH   (8),
    .MAX_WORD_LEN (8),
    .VOCAB_DEPTH  (16),
    .TOKEN_WIDTH  (8),
    .SEP_CHAR     (8'h20),
    .VADDR_W      (7)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .drop_unk (drop_unk),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Synchronous vocab memory plus monitors for reads, token handshakes and done pulses.
  always @(posedge clk) begin
    if (bus.vocab_rd_en) begin
      bus.vocab_rd_data <= vocab[bus.vocab_addr];
      addrQ.push_back(bus.vocab_addr);
    end
    if (bus.tok_valid && bus.tok_ready) begin
      tokQ.push_back({bus.tok_data, bus.tok_unk, bus.tok_last});
    end
    if (done) begin
      doneCount <= doneCount + 1;
    end
  end

  // Global safety net in case a bounded wait is itself mis-bounded.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one character and hold it until accepted; reports cycles spent waiting.
  task automatic applyStimulus(input logic [7:0] c, input logic last, output int waited);
    waited = 0;
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    bus.char_last  = last;
    while (!bus.char_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("charReady", 32'(bus.char_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    bus.char_last  = 1'b0;
  endtask

  task automatic sendString(input string s, input logic lastOnFinal);
    int w;
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i], lastOnFinal && (i == s.len() - 1), w);
    end
  endtask

  task automatic startStream(input logic drop);
    @(negedge clk);
    start    = 1'b1;
    drop_unk = drop;
    @(negedge clk);
    start    = 1'b0;
    drop_unk = 1'b0;
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
  endtask

  task automatic waitDone(input string tag);
    int base;
    int n;
    base = doneCount;
    n = 0;
    while (doneCount == base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "Done"}, 32'(doneCount - base), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "DoneOnce"}, 32'(doneCount - base), 32'd1);
    checkOutput({tag, "Idle"}, 32'(busy), 32'd0);
  endtask

  task automatic checkToken(input string tag, input logic [7:0] data, input logic unk, input logic last);
    logic [9:0] t;
    checkOutput({tag, "Present"}, 32'(tokQ.size() > 0), 32'd1);
    if (tokQ.size() > 0) begin
      t = tokQ.pop_front();
      checkOutput({tag, "DataUnkLast"}, 32'(t), 32'({data, unk, last}));
    end
  endtask

  initial begin
    int w;
    int base;
    int n;
    int expAddr [4];

    for (int i = 0; i < 128; i++) vocab[i] = 8'h00;
    vocab[0] = 8'h61;
    vocab[8] = 8'h68;
    vocab[9] = 8'h69;

    rst_n          = 1'b0;
    start          = 1'b0;
    drop_unk       = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.char_last  = 1'b0;
    bus.tok_ready  = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstCharReady", 32'(bus.char_ready), 32'd0);
    checkOutput("rstTokValid", 32'(bus.tok_valid), 32'd0);
    checkOutput("rstRdEn", 32'(bus.vocab_rd_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleCharReady", 32'(bus.char_ready), 32'd0);

    // Test 1: "hi" matches entry 1.
    $display("[TB] test 1: single word match");
    addrQ.delete();
    startStream(1'b0);
    sendString("hi", 1'b1);
    waitDone("t1");
    checkToken("t1Tok", 8'd1, 1'b0, 1'b1);
    checkOutput("t1TokCount", 32'(tokQ.size()), 32'd0);
    expAddr = '{0, 8, 9, 10};
    checkOutput("t1AddrCount", 32'(addrQ.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < addrQ.size()) checkOutput("t1Addr", 32'(addrQ[i]), 32'(expAddr[i]));
    end

    // Test 2: "a b" with UNK emission.
    $display("[TB] test 2: unknown word emits UNK");
    tokQ.delete();
    startStream(1'b0);
    sendString("a b", 1'b1);
    waitDone("t2");
    checkToken("t2Tok0", 8'd0, 1'b0, 1'b0);
    checkToken("t2Tok1", 8'd255, 1'b1, 1'b1);

    // Test 3: same stream, unknown words dropped.
    $display("[TB] test 3: unknown word dropped");
    tokQ.delete();
    startStream(1'b1);
    sendString("a b", 1'b1);
    waitDone("t3");
    checkToken("t3Tok0", 8'd0, 1'b0, 1'b0);
    checkOutput("t3TokCount", 32'(tokQ.size()), 32'd0);

    // Test 4: 10-character word truncates and skips the search.
    $display("[TB] test 4: truncated word");
    tokQ.delete();
    addrQ.delete();
    startStream(1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h61 + 8'(i), (i == 9), w);
      checkOutput("t4NoStall", 32'(w), 32'd0);
    end
    waitDone("t4");
    checkOutput("t4NoReads", 32'(addrQ.size()), 32'd0);
    checkToken("t4Tok", 8'd255, 1'b1, 1'b1);

    // Test 5: empty words skipped, token held under backpressure.
    $display("[TB] test 5: separators and backpressure");
    tokQ.delete();
    bus.tok_ready = 1'b0;
    startStream(1'b0);
    sendString("  a ", 1'b0);
    n = 0;
    while (!bus.tok_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5Valid", 32'(bus.tok_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5Held", 32'({bus.tok_valid, bus.tok_data, bus.tok_unk, bus.tok_last}), 32'({1'b1, 8'd0, 1'b0, 1'b0}));
    end
    checkOutput("t5NoHsYet", 32'(tokQ.size()), 32'd0);
    bus.tok_ready = 1'b1;
    applyStimulus(8'h20, 1'b1, w);
    waitDone("t5");
    checkToken("t5Tok", 8'd0, 1'b0, 1'b0);
    checkOutput("t5TokCount", 32'(tokQ.size()), 32'd0);

    // Test 6: reset during FETCH of entry 3 aborts silently.
    $display("[TB] test 6: reset mid-search");
    tokQ.delete();
    startStream(1'b0);
    sendString("zz", 1'b1);
    n = 0;
    while (!(bus.vocab_rd_en && bus.vocab_addr == 7'd24) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6FetchE3", 32'(bus.vocab_rd_en && bus.vocab_addr == 7'd24), 32'd1);
    base = doneCount;
    rst_n = 1'b0;
    #1;
    checkOutput("t6BusyInReset", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("t6BusyAfter", 32'(busy), 32'd0);
    checkOutput("t6ReadyAfter", 32'(bus.char_ready), 32'd0);
    checkOutput("t6TokValidAfter", 32'(bus.tok_valid), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("t6StillIdle", 32'(busy), 32'd0);
    checkOutput("t6NoToken", 32'(tokQ.size()), 32'd0);
    checkOutput("t6NoDone", 32'(doneCount - base), 32'd0);
    startStream(1'b0);
    sendString("hi", 1'b1);
    waitDone("t6b");
    checkToken("t6bTok", 8'd1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/token_encoder.md
Name: token_encoder

Overview:
- Streaming word-level tokenizer; parametrised successor to the fixed 8-bit/16-entry encoder.
- Accepts a character stream on a valid/ready input and splits it into words on a separator character.
- Looks each word up against a vocabulary memory through an external synchronous read port.
- Emits one token ID per word on a valid/ready output, with a configurable unknown-word policy, truncation handling and end-of-stream signalling.

Parameters:
- CHAR_WIDTH, 8: bits per character.
- MAX_WORD_LEN, 8: characters per vocab slot and word-buffer depth.
- VOCAB_DEPTH, 16: number of vocab entries; must be < 2^TOKEN_WIDTH.
- TOKEN_WIDTH, 8: token ID width.
- SEP_CHAR, 8'h20: word separator.
- VADDR_W, $clog2(VOCAB_DEPTH*MAX_WORD_LEN): vocab address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  pulse; begins a stream; ignored unless idle
- drop_unk  in  1  sampled on start: 1 = unmatched words emit nothing; 0 = emit UNK
- char_valid  in  1  input character valid
- char_ready  out  1  block accepts character
- char_data  in  CHAR_WIDTH  input character
- char_last  in  1  final character of stream
- vocab_rd_en  out  1  vocab read strobe
- vocab_addr  out  VADDR_W  entry*MAX_WORD_LEN + char index
- vocab_rd_data  in  CHAR_WIDTH  read data, valid 1 cycle after vocab_rd_en
- tok_valid  out  1  token valid
- tok_ready  in  1  consumer accepts token
- tok_data  out  TOKEN_WIDTH  matched entry index, or UNK_ID
- tok_unk  out  1  token is UNK
- tok_last  out  1  token closes the stream
- busy  out  1  not idle
- done  out  1  one-cycle pulse at end of stream

Behaviour:
- **Reset.** Synchronous: rst_n low at a clk edge forces IDLE and clears the word buffer, length, truncate flag and mode. All outputs read 0 during and after reset. Reset mid-search or mid-handshake aborts silently; no partial token is emitted.
- **UNK_ID** = 2^TOKEN_WIDTH-1.
- **IDLE.** On start, latch drop_unk and go to COLLECT.
- **COLLECT.**
  - char_ready = 1 in COLLECT only.
  - Non-separator char: written to buf[len] if len < MAX_WORD_LEN and len increments. Otherwise the char is consumed, discarded and the trunc flag is set.
  - Separator, or any char with char_last:
    - Ends the word; a char_last non-separator is stored first.
    - If len = 0, no search: char_last goes to DONE, otherwise stay in COLLECT (empty words are skipped).
    - Else zero-pad buf[len..MAX_WORD_LEN-1], record last_flag = char_last, go to SEARCH with e = 0, k = 0.
- **SEARCH.** Two-cycle steps.
  - FETCH: vocab_rd_en = 1, vocab_addr = e*MAX_WORD_LEN + k.
  - CMP: v = vocab_rd_data, w = buf[k].
    - v != w: mismatch. If e = VOCAB_DEPTH-1, no match; else e++, k = 0, FETCH.
    - v == w and v == 0: match.
    - v == w and v != 0: k++; if k = MAX_WORD_LEN, match; else FETCH.
  - trunc set: SEARCH is skipped; the word is unmatched.
  - match: tok_data = e, tok_unk = 0, go to EMIT.
  - unmatched with drop_unk = 0: tok_data = UNK_ID, tok_unk = 1, go to EMIT.
  - unmatched with drop_unk = 1: no token; go to DONE if last_flag, else clear the buffer and go to COLLECT.
  - First entry wins on duplicates.
- **EMIT.** tok_valid is asserted in the cycle after the resolving CMP. tok_data, tok_unk and tok_last (= last_flag) are held stable until tok_ready. On the handshake: go to DONE if last_flag, else clear the buffer and go to COLLECT. tok_ready while tok_valid = 0 is ignored.
- **DONE.** done = 1 for one cycle, then IDLE. busy = 1 in every state except IDLE.
- **End of stream.** tok_last is raised only when the final word yields a token. A stream ending on a separator or a dropped word gives done without tok_last.
- **Latency.** Match at entry e, position k costs 2*(steps) cycles; tok_valid rises the cycle after the last CMP.

Decomposition:
- **encoder_pkg:** state enum (IDLE, COLLECT, FETCH, CMP, EMIT, DONE) and an UNK_ID function of TOKEN_WIDTH.
- **tok_word_buf** (sub-module): word buffer register array with write, length, zero-pad, trunc flag, clear and indexed read.
- **FSM, search counters and handshakes:** in token_encoder.

Test Plan:
1. Vocab entry0 = "a",0; entry1 = "hi",0. Stream "hi" + char_last, tok_ready = 1 → tok_data = 1, tok_unk = 0, tok_last = 1, then done pulse. vocab_rd_en sequence addr 0, 8, 9, 10.
2. Stream "a b" with drop_unk = 0 ('b' not in vocab), tok_ready = 1 → tokens 0 then 255 with tok_unk = 1. tok_last only on the second token.
3. Same stream with drop_unk = 1 → single token 0 with tok_last = 0; done still pulses.
4. 10-char word, MAX_WORD_LEN = 8 → all 10 chars accepted (char_ready = 1 throughout); no vocab reads for that word; emits 255 with tok_unk = 1.
5. Separators "  a  " with char_last on the final space, plus tok_ready low 5 cycles → one token 0, held stable for 5 cycles; zero tokens for empty words; tok_last = 0.
6. rst_n low for 1 cycle during FETCH of entry 3 → next cycle idle, busy = 0, no token. A fresh start then tokenizes normally.
